anatool_duty_logger: RTL



---
 rtl/anatool_duty_logger_if.sv | 21 ++
 rtl/anatool_duty_logger.sv | 136 +++++++++++++
 2 files changed

// File: rtl/anatool_duty_logger_if.sv
// Sample stream from the duty-measurement stage plus the TinyQV peripheral register bus.
// Neither channel has a ready: sample_valid is a one-cycle pulse that is always taken, and data_write is a one-cycle strobe.
interface anatool_duty_logger_if;
   logic       sample_valid;
   logic [7:0] sample;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       irq;

   modport master (
      output sample_valid, sample, address, data_write, data_in,
      input  data_out, irq
   );

   modport slave (
      input  sample_valid, sample, address, data_write, data_in,
      output data_out, irq
   );
endinterface

// File: rtl/anatool_duty_logger.sv
// Duty-sample logger: a FIFO of recent samples plus running min/max/EMA statistics.
// Firmware reads and configures it through a small register map.
module anatool_duty_logger #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   anatool_duty_logger_if.slave  bus
);

   logic [7:0]        mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr, ptr_diff;
   logic              full_q, overflow_q, empty;
   logic [4:0]        count;
   logic [7:0]        min_q, max_q;
   logic [15:0]       acc_q;
   logic              stats_valid_q;
   logic [2:0]        k_q;
   logic [3:0]        thr_q;
   logic              irq_q;

   logic              wr_reg0, wr_reg1, wr_reg5;
   logic              flush, stats_rst, ovf_clr, ovf_set;
   logic              do_pop, do_push;

   logic [7:0]        min_base, max_base, min_d, max_d;
   logic [15:0]       acc_base, acc_d;
   logic              valid_base, valid_d;
   logic signed [16:0] diff, step;

   assign wr_reg0   = bus.data_write && (bus.address == 4'd0);
   assign wr_reg1   = bus.data_write && (bus.address == 4'd1);
   assign wr_reg5   = bus.data_write && (bus.address == 4'd5);
   assign flush     = wr_reg1 && bus.data_in[2];
   assign stats_rst = wr_reg1 && bus.data_in[1];
   assign ovf_clr   = wr_reg1 && bus.data_in[0];

   assign ptr_diff  = wr_ptr - rd_ptr;
   assign count     = full_q ? 5'(DEPTH) : 5'(ptr_diff);
   assign empty     = !full_q && (wr_ptr == rd_ptr);

   // A pop on an empty FIFO is dropped; a push into a full FIFO survives only if a pop frees a slot.
   assign do_pop    = wr_reg0 && !empty;
   assign do_push   = bus.sample_valid && !flush && (!full_q || do_pop);
   assign ovf_set   = bus.sample_valid && !flush && full_q && !do_pop;

   always_ff @(posedge clk) begin
      if (rst_n && do_push) mem[wr_ptr] <= bus.sample;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full_q <= 1'b0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      full_q <= ((wr_ptr + AW'(1)) == rd_ptr);
            else if (do_pop && !do_push) full_q <= 1'b0;
         end
         // A fresh overflow in the same cycle as a clear stays visible.
         if (ovf_set)      overflow_q <= 1'b1;
         else if (ovf_clr) overflow_q <= 1'b0;
      end
   end

   // Stats reset is applied first so a coincident sample seeds the fresh statistics.
   always_comb begin
      min_base   = stats_rst ? 8'hFF    : min_q;
      max_base   = stats_rst ? 8'h00    : max_q;
      acc_base   = stats_rst ? 16'h0000 : acc_q;
      valid_base = stats_rst ? 1'b0     : stats_valid_q;
      min_d      = min_base;
      max_d      = max_base;
      acc_d      = acc_base;
      valid_d    = valid_base;
      diff       = $signed({1'b0, bus.sample, 8'h00}) - $signed({1'b0, acc_base});
      step       = diff >>> k_q;
      if (bus.sample_valid) begin
         if (bus.sample < min_base) min_d = bus.sample;
         if (bus.sample > max_base) max_d = bus.sample;
         if (!valid_base) begin
            acc_d   = {bus.sample, 8'h00};
            valid_d = 1'b1;
         end else begin
            acc_d   = acc_base + 16'(step);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         min_q         <= 8'hFF;
         max_q         <= 8'h00;
         acc_q         <= 16'h0000;
         stats_valid_q <= 1'b0;
         k_q           <= 3'd3;
         thr_q         <= 4'(DEPTH / 2);
         irq_q         <= 1'b0;
      end else begin
         min_q         <= min_d;
         max_q         <= max_d;
         acc_q         <= acc_d;
         stats_valid_q <= valid_d;
         if (wr_reg5) begin
            k_q   <= bus.data_in[6:4];
            thr_q <= bus.data_in[3:0];
         end
         irq_q <= ((thr_q != 4'd0) && (count >= {1'b0, thr_q})) || overflow_q;
      end
   end

   always_comb begin
      bus.data_out = 8'h00;
      case (bus.address)
         4'd0: bus.data_out = empty ? 8'h00 : mem[rd_ptr];
         4'd1: bus.data_out = {overflow_q, empty, full_q, stats_valid_q, count[3:0]};
         4'd2: bus.data_out = min_q;
         4'd3: bus.data_out = max_q;
         4'd4: bus.data_out = acc_q[15:8];
         4'd5: bus.data_out = {1'b0, k_q, thr_q};
         default: bus.data_out = 8'h00;
      endcase
   end

   assign bus.irq = irq_q;

endmodule
